// File: rtl/mm_result_wb_pkg.sv
// Shared definitions for the Montgomery-multiplier result write-back stage:
// destination FIFO codes, default operand size and FSM state encodings.
package mm_result_wb_pkg;

    localparam int NUM_WORDS_DEF = 16;
    localparam int NUM_DST       = 6;

    localparam logic [2:0] DST_SS0   = 3'd0;
    localparam logic [2:0] DST_SS1   = 3'd1;
    localparam logic [2:0] DST_SS2   = 3'd2;
    localparam logic [2:0] DST_CS    = 3'd3;
    localparam logic [2:0] DST_CS_PR = 3'd4;
    localparam logic [2:0] DST_SS_PR = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_DECIDE  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } wb_state_e;

    // Codes 6 and 7 have no FIFO behind them and map to no write enable.
    function automatic logic [5:0] dest_onehot(input logic [2:0] dest);
        logic [5:0] oh;
        case (dest)
            DST_SS0:   oh = 6'b000001;
            DST_SS1:   oh = 6'b000010;
            DST_SS2:   oh = 6'b000100;
            DST_CS:    oh = 6'b001000;
            DST_CS_PR: oh = 6'b010000;
            DST_SS_PR: oh = 6'b100000;
            default:   oh = 6'b000000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mm_wb_buf.sv
// Result buffer: raw word T[k] and tentatively reduced word D[k] share one
// write address; the read port returns D or T according to use_d.
module mm_wb_buf
    import mm_result_wb_pkg::*;
#(
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [CNT_W-1:0] waddr,
    input  logic [31:0]      t_wdata,
    input  logic [31:0]      d_wdata,
    input  logic [CNT_W-1:0] raddr,
    input  logic             use_d,
    output logic [31:0]      rdata
);

    localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [31:0] t_mem_q [NUM_WORDS];
    logic [31:0] d_mem_q [NUM_WORDS];

    // Storage is left unreset: contents only matter after being written.
    always_ff @(posedge clk) begin
        if (we) begin
            t_mem_q[waddr[AW-1:0]] <= t_wdata;
            d_mem_q[waddr[AW-1:0]] <= d_wdata;
        end
    end

    assign rdata = use_d ? d_mem_q[raddr[AW-1:0]] : t_mem_q[raddr[AW-1:0]];

endmodule

// File: rtl/mm_result_wb.sv
// Write-back stage: collects the word-serial Montgomery result, applies the
// final conditional subtraction and drains it into the selected operand FIFO.
module mm_result_wb
    import mm_result_wb_pkg::*;
#(
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int CNT_W     = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mm_clear,
    input  logic [2:0]  dest_sel,
    input  logic        res_valid,
    input  logic [31:0] res_word,
    input  logic [31:0] res_n_word,
    input  logic        res_last,
    input  logic        res_carry,
    output logic        res_ready,
    input  logic [5:0]  fifo_full,
    output logic [5:0]  wr_en,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        len_err
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    wb_state_e          state_q, state_d;
    logic [2:0]         dest_q, dest_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   nw_q, nw_d;
    logic [CNT_W-1:0]   rd_q, rd_d;
    logic               borrow_q, borrow_d;
    logic               carry_q, carry_d;
    logic               use_d_q, use_d_d;
    logic               len_err_q, len_err_d;
    logic               done_q, done_d;
    logic [5:0]         wr_en_q, wr_en_d;
    logic [31:0]        wr_data_q, wr_data_d;

    logic               accept_s;
    logic [CNT_W-1:0]   idx_s;
    logic               borrow_in_s;
    logic [32:0]        diff_s;
    logic               last_idx_s;
    logic               dest_ok_s;
    logic               dest_full_s;
    logic [31:0]        rdata_s;

    assign res_ready   = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    assign accept_s    = res_valid & res_ready;
    assign idx_s       = (state_q == ST_COLLECT) ? cnt_q : {CNT_W{1'b0}};
    assign borrow_in_s = (state_q == ST_COLLECT) ? borrow_q : 1'b0;
    assign diff_s      = {1'b0, res_word} - {1'b0, res_n_word} - {32'd0, borrow_in_s};
    assign last_idx_s  = (idx_s == LAST_IDX);
    assign dest_ok_s   = (dest_q < 3'(NUM_DST));
    // Unmapped destinations never stall, so their data is discarded at full rate.
    assign dest_full_s = dest_ok_s ? fifo_full[dest_q] : 1'b0;

    mm_wb_buf #(
        .NUM_WORDS (NUM_WORDS),
        .CNT_W     (CNT_W)
    ) u_buf (
        .clk     (clk),
        .we      (accept_s),
        .waddr   (idx_s),
        .t_wdata (res_word),
        .d_wdata (diff_s[31:0]),
        .raddr   (rd_q),
        .use_d   (use_d_q),
        .rdata   (rdata_s)
    );

    // Next-state and datapath update; mm_clear overrides everything last.
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        cnt_d     = cnt_q;
        nw_d      = nw_q;
        rd_d      = rd_q;
        borrow_d  = borrow_q;
        carry_d   = carry_q;
        use_d_d   = use_d_q;
        len_err_d = len_err_q;
        done_d    = 1'b0;
        wr_en_d   = 6'b000000;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (accept_s) begin
                    if (state_q == ST_IDLE) begin
                        dest_d = dest_sel;
                    end else begin
                        dest_d = dest_q;
                    end
                    cnt_d    = idx_s + CNT_ONE;
                    nw_d     = idx_s + CNT_ONE;
                    borrow_d = diff_s[32];
                    if (res_last || last_idx_s) begin
                        state_d = ST_DECIDE;
                        carry_d = res_last & res_carry;
                        // Error when the frame ends early or runs past the buffer.
                        if (res_last != last_idx_s) begin
                            len_err_d = 1'b1;
                        end else begin
                            len_err_d = len_err_q;
                        end
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DECIDE: begin
                use_d_d = carry_q | ~borrow_q;
                rd_d    = {CNT_W{1'b0}};
                state_d = ST_DRAIN;
                if (!dest_ok_s) begin
                    len_err_d = 1'b1;
                end else begin
                    len_err_d = len_err_q;
                end
            end
            ST_DRAIN: begin
                if (!dest_full_s) begin
                    wr_en_d   = dest_onehot(dest_q);
                    wr_data_d = rdata_s;
                    rd_d      = rd_q + CNT_ONE;
                    if (rd_q == (nw_q - CNT_ONE)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (mm_clear) begin
            state_d   = ST_IDLE;
            cnt_d     = {CNT_W{1'b0}};
            rd_d      = {CNT_W{1'b0}};
            borrow_d  = 1'b0;
            carry_d   = 1'b0;
            len_err_d = 1'b0;
            done_d    = 1'b0;
            wr_en_d   = 6'b000000;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            dest_q    <= 3'd0;
            cnt_q     <= {CNT_W{1'b0}};
            nw_q      <= {CNT_W{1'b0}};
            rd_q      <= {CNT_W{1'b0}};
            borrow_q  <= 1'b0;
            carry_q   <= 1'b0;
            use_d_q   <= 1'b0;
            len_err_q <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 6'b000000;
            wr_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            cnt_q     <= cnt_d;
            nw_q      <= nw_d;
            rd_q      <= rd_d;
            borrow_q  <= borrow_d;
            carry_q   <= carry_d;
            use_d_q   <= use_d_d;
            len_err_q <= len_err_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign len_err = len_err_q;
    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;

endmodule
